// File: rtl/third_assignment_c_dff_if.sv
// Data bus of the D-register pipeline: d in, q out, plus optional per-bit edge pulses.
// Edge outputs exist only when THIRD_ASSIGNMENT_C_EDGE_EN is defined.
interface third_assignment_c_dff_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
`ifdef THIRD_ASSIGNMENT_C_EDGE_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (output d, input q, input rise, input fall);
  modport slave  (input d, output q, output rise, output fall);
`else
  modport master (output d, input q);
  modport slave  (input d, output q);
`endif
endinterface

// File: rtl/third_assignment_c_dff.sv
// Parameterised D-register pipeline (WIDTH bits, DEPTH stages) with async active-high reset.
// Define THIRD_ASSIGNMENT_C_EDGE_EN to add registered-derived per-bit rise/fall pulses on q.
module third_assignment_c_dff #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                   clk,
  input logic                   reset,
  third_assignment_c_dff_if.slave bus
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= bus.d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // q comes straight from the last flop: no path from d, no glitches.
  assign bus.q = r_stage[DEPTH-1];

`ifdef THIRD_ASSIGNMENT_C_EDGE_EN
  logic [WIDTH-1:0] r_q_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_prev <= RESET_VAL;
    end else begin
      r_q_prev <= r_stage[DEPTH-1];
    end
  end

  // Both operands are flops, so each pulse lasts exactly one clk period after q changes.
  assign bus.rise = r_stage[DEPTH-1] & ~r_q_prev;
  assign bus.fall = ~r_stage[DEPTH-1] & r_q_prev;
`endif

endmodule

// File: tb/tb_third_assignment_c_dff.sv
// Directed bench: default 1-bit flop plus an 8-bit, 3-deep pipeline with non-zero reset value.
module tb_third_assignment_c_dff;

  logic clk;
  logic reset;

  third_assignment_c_dff_if #(.WIDTH(1)) bus1 ();
  third_assignment_c_dff_if #(.WIDTH(8)) bus8 ();

  third_assignment_c_dff u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  third_assignment_c_dff #(
    .WIDTH     (8),
    .DEPTH     (3),
    .RESET_VAL (8'h5A)
  ) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  // Rising edges at 20, 40, 60 ... ns.
  initial clk = 1'b1;
  always #10 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] vec_d   [8] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h81, 8'h81, 8'h81};
  logic [7:0] vec_exp [8] = '{8'h5A, 8'h5A, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h81};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    bus1.d = 1'b0;
    bus8.d = 8'h00;
    #2;
    chk("w1_reset_q", {7'b0, bus1.q}, 8'h00);
    chk("w8_reset_q", bus8.q, 8'h5A);
    #8;  // t=10
    reset = 1'b0;
    tick();  // t=21
    chk("w1_release_q", {7'b0, bus1.q}, 8'h00);
    #9;  // t=30
    bus1.d = 1'b1;
    tick();  // t=41
    chk("w1_capture_1", {7'b0, bus1.q}, 8'h01);
    tick();  // t=61
    chk("w1_hold_1", {7'b0, bus1.q}, 8'h01);
    #4;  // t=65: async reset between edges with d=1
    reset = 1'b1;
    #1;
    chk("w1_async_reset", {7'b0, bus1.q}, 8'h00);
    tick();  // t=81, edge seen while reset high
    chk("w1_reset_held", {7'b0, bus1.q}, 8'h00);
    #9;  // t=90
    reset = 1'b0;
    tick();  // t=101
    chk("w1_first_capture", {7'b0, bus1.q}, 8'h01);
    #9;  // t=110
    bus1.d = 1'b0;
    tick();  // t=121
    chk("w1_capture_0", {7'b0, bus1.q}, 8'h00);
    tick();
    chk("w1_hold_0_a", {7'b0, bus1.q}, 8'h00);
    tick();  // t=161
    chk("w1_hold_0_b", {7'b0, bus1.q}, 8'h00);
    #4;  // t=165: 5ns pulse between edges
    bus1.d = 1'b1;
    #2;
    chk("w1_no_comb_path", {7'b0, bus1.q}, 8'h00);
    #3;  // t=170
    bus1.d = 1'b0;
    tick();  // t=181
    chk("w1_glitch_reject", {7'b0, bus1.q}, 8'h00);

    // Pipeline phase: reset to reload 5A, then stream vectors.
    #4;
    reset = 1'b1;
    #1;
    chk("w8_async_reset", bus8.q, 8'h5A);
    #4;  // t=190
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus8.d = vec_d[i];
      tick();
      chk($sformatf("w8_pipe_%0d", i), bus8.q, vec_exp[i]);
    end
    // Reset mid-stream discards the 81s in flight.
    #4;
    reset = 1'b1;
    #1;
    chk("w8_mid_reset", bus8.q, 8'h5A);
    tick();
    chk("w8_mid_reset_held", bus8.q, 8'h5A);
    #4;
    reset = 1'b0;
    bus8.d = 8'h00;
    tick();
    chk("w8_after_mid_reset", bus8.q, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
